// File: rtl/y86_pkg.sv
// Shared Y86 definitions: register IDs, default widths and reset values for the register file.
package y86_pkg;

   localparam int          DATA_W_DEF  = 32;
   localparam int          NREGS_DEF   = 8;
   localparam logic [31:0] SP_INIT_DEF = 32'h0000_0F00;

   localparam logic [3:0] REG_EAX = 4'h0;
   localparam logic [3:0] REG_ECX = 4'h1;
   localparam logic [3:0] REG_EDX = 4'h2;
   localparam logic [3:0] REG_EBX = 4'h3;
   localparam logic [3:0] REG_ESP = 4'h4;
   localparam logic [3:0] REG_EBP = 4'h5;
   localparam logic [3:0] REG_ESI = 4'h6;
   localparam logic [3:0] REG_EDI = 4'h7;
   localparam logic [3:0] RNONE   = 4'hF;

   // Write-back drives ID 6 for the stack pointer in this core.
   localparam int SP_ID_DEF = 6;

   function automatic logic id_is_valid(input logic [3:0] id, input int nregs);
      return int'({28'd0, id}) < nregs;
   endfunction

endpackage

// File: rtl/y86_regfile_read_mux.sv
// One register-file read port: range check, zero for invalid IDs, optional same-cycle forwarding.
module y86_regfile_read_mux
   import y86_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int NREGS  = NREGS_DEF,
   parameter bit BYPASS = 1'b0
) (
   input  logic [DATA_W-1:0] regs [NREGS],
   input  logic [3:0]        rd_id,
   input  logic              wr_en1,
   input  logic [3:0]        wr_id1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              wr_en2,
   input  logic [3:0]        wr_id2,
   input  logic [DATA_W-1:0] wr_data2,
   output logic [DATA_W-1:0] rd_data
);

   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   logic [DATA_W-1:0] stored;

   always_comb begin
      stored = '0;
      if (id_is_valid(rd_id, NREGS))
         stored = regs[rd_id[IDX_W-1:0]];
   end

   generate
      if (BYPASS) begin : g_bypass
         // Port 2 is checked last so it wins, matching the commit priority.
         always_comb begin
            rd_data = stored;
            if (wr_en1 && id_is_valid(wr_id1, NREGS) && (wr_id1 == rd_id))
               rd_data = wr_data1;
            if (wr_en2 && id_is_valid(wr_id2, NREGS) && (wr_id2 == rd_id))
               rd_data = wr_data2;
         end
      end else begin : g_direct
         logic unused_bypass;
         assign unused_bypass = ^{wr_en1, wr_id1, wr_data1, wr_en2, wr_id2, wr_data2};
         assign rd_data = stored;
      end
   endgenerate

endmodule

// File: rtl/y86_register_file.sv
// Y86 architectural register file: two write-back ports, two decode read ports, one debug port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto valA/valB.
module y86_register_file
   import y86_pkg::*;
#(
   parameter int              DATA_W  = DATA_W_DEF,
   parameter int              NREGS   = NREGS_DEF,
   parameter int              SP_ID   = SP_ID_DEF,
   parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              regWrite1,
   input  logic [3:0]        regReg1,
   input  logic [DATA_W-1:0] regValue1,
   input  logic              regWrite2,
   input  logic [3:0]        regReg2,
   input  logic [DATA_W-1:0] regValue2,
   input  logic [3:0]        srcA,
   input  logic [3:0]        srcB,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB,
   input  logic [3:0]        dbgReg,
   output logic [DATA_W-1:0] dbgValue,
   output logic [15:0]       writeCount
);

   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic [DATA_W-1:0] regs [NREGS];
   logic [15:0]       write_count;
   logic              commit1;
   logic              commit2;
   logic [1:0]        commit_n;
   logic [16:0]       count_sum;

   assign commit1 = regWrite1 && id_is_valid(regReg1, NREGS);
   assign commit2 = regWrite2 && id_is_valid(regReg2, NREGS);

   // A same-register conflict is a single architectural write.
   always_comb begin
      commit_n = 2'(commit1) + 2'(commit2);
      if (commit1 && commit2 && (regReg1 == regReg2))
         commit_n = 2'd1;
   end

   assign count_sum = {1'b0, write_count} + {15'd0, commit_n};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= (i == SP_ID) ? SP_INIT : '0;
         write_count <= '0;
      end else begin
         if (commit1)
            regs[regReg1[IDX_W-1:0]] <= regValue1;
         if (commit2)
            regs[regReg2[IDX_W-1:0]] <= regValue2;
         write_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
      end
   end

   assign writeCount = write_count;

   y86_regfile_read_mux #(.DATA_W(DATA_W), .NREGS(NREGS), .BYPASS(BYPASS_EN)) u_read_a (
      .regs(regs), .rd_id(srcA),
      .wr_en1(regWrite1), .wr_id1(regReg1), .wr_data1(regValue1),
      .wr_en2(regWrite2), .wr_id2(regReg2), .wr_data2(regValue2),
      .rd_data(valA)
   );

   y86_regfile_read_mux #(.DATA_W(DATA_W), .NREGS(NREGS), .BYPASS(BYPASS_EN)) u_read_b (
      .regs(regs), .rd_id(srcB),
      .wr_en1(regWrite1), .wr_id1(regReg1), .wr_data1(regValue1),
      .wr_en2(regWrite2), .wr_id2(regReg2), .wr_data2(regValue2),
      .rd_data(valB)
   );

   // The debug port always reflects committed state only.
   y86_regfile_read_mux #(.DATA_W(DATA_W), .NREGS(NREGS), .BYPASS(1'b0)) u_read_dbg (
      .regs(regs), .rd_id(dbgReg),
      .wr_en1(regWrite1), .wr_id1(regReg1), .wr_data1(regValue1),
      .wr_en2(regWrite2), .wr_id2(regReg2), .wr_data2(regValue2),
      .rd_data(dbgValue)
   );

endmodule

// File: tb/tb_y86_register_file.sv
// Scoreboard testbench for y86_register_file: directed and random writes against an array model.
module tb_y86_register_file;
   import y86_pkg::*;

   logic        clock;
   logic        reset_n;
   logic        regWrite1;
   logic [3:0]  regReg1;
   logic [31:0] regValue1;
   logic        regWrite2;
   logic [3:0]  regReg2;
   logic [31:0] regValue2;
   logic [3:0]  srcA;
   logic [3:0]  srcB;
   logic [31:0] valA;
   logic [31:0] valB;
   logic [3:0]  dbgReg;
   logic [31:0] dbgValue;
   logic [15:0] writeCount;

   typedef struct {
      string       name;
      int          port;
      logic [31:0] value;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_regs [8];
   int          model_count;
   int          errors;
   int          checks;

   y86_register_file dut (
      .clock(clock), .reset_n(reset_n),
      .regWrite1(regWrite1), .regReg1(regReg1), .regValue1(regValue1),
      .regWrite2(regWrite2), .regReg2(regReg2), .regValue2(regValue2),
      .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
      .dbgReg(dbgReg), .dbgValue(dbgValue), .writeCount(writeCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] modelRead(input logic [3:0] id);
      if (id[3] == 1'b0)
         return model_regs[id[2:0]];
      return 32'h0;
   endfunction

   // What decode sees before the edge: stored value, or forwarded write data when bypass is built in.
   function automatic logic [31:0] modelDecodeRead(input logic [3:0] id,
                                                   input logic w1, input logic [3:0] r1, input logic [31:0] v1,
                                                   input logic w2, input logic [3:0] r2, input logic [31:0] v2);
`ifdef REGFILE_BYPASS_EN
      if (w2 && !r2[3] && r2 == id) return v2;
      if (w1 && !r1[3] && r1 == id) return v1;
`else
      if (w1 && w2 && r1 == r2 && v1 == v2) return modelRead(id);
`endif
      return modelRead(id);
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < 8; i++)
         model_regs[i] = (i == 6) ? 32'h0000_0F00 : 32'h0;
      model_count = 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic pushExpect(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] d, input logic [31:0] c);
      exp_q.push_back('{{tag, ".valA"}, 0, a});
      exp_q.push_back('{{tag, ".valB"}, 1, b});
      exp_q.push_back('{{tag, ".dbgValue"}, 2, d});
      exp_q.push_back('{{tag, ".writeCount"}, 3, c});
   endtask

   // Drives one cycle of write/read traffic; expectations describe the outputs before the next edge.
   task automatic applyStimulus(input string tag,
                                input logic w1, input logic [3:0] r1, input logic [31:0] v1,
                                input logic w2, input logic [3:0] r2, input logic [31:0] v2,
                                input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] dr,
                                input bit do_check);
      int n;
      @(posedge clock);
      #1;
      regWrite1 = w1; regReg1 = r1; regValue1 = v1;
      regWrite2 = w2; regReg2 = r2; regValue2 = v2;
      srcA = sa; srcB = sb; dbgReg = dr;
      if (do_check)
         pushExpect(tag, modelDecodeRead(sa, w1, r1, v1, w2, r2, v2),
                    modelDecodeRead(sb, w1, r1, v1, w2, r2, v2),
                    modelRead(dr), 32'(model_count));
      n = 0;
      if (w1 && !r1[3]) begin
         model_regs[r1[2:0]] = v1;
         n++;
      end
      if (w2 && !r2[3]) begin
         if (!(w1 && !r1[3] && r1 == r2)) n++;
         model_regs[r2[2:0]] = v2;
      end
      model_count = (model_count + n > 65535) ? 65535 : model_count + n;
   endtask

   // Asserts reset mid-cycle while both write ports are active; nothing but reset values may appear.
   task automatic applyReset(input string tag);
      @(posedge clock);
      #1;
      regWrite1 = 1'b1; regReg1 = REG_EDX; regValue1 = 32'hAAAA_AAAA;
      regWrite2 = 1'b1; regReg2 = REG_ESI; regValue2 = 32'h5555_5555;
      srcA = REG_ESI; srcB = REG_EDX; dbgReg = REG_EAX;
      #2;
      reset_n = 1'b0;
      #1;
      modelReset();
      pushExpect({tag, ".async"}, 32'h0000_0F00, 32'h0, 32'h0, 32'h0);
      @(posedge clock);
      #1;
      srcA = REG_EDX; srcB = REG_ESI; dbgReg = REG_ESI;
      pushExpect({tag, ".held"}, 32'h0, 32'h0000_0F00, 32'h0000_0F00, 32'h0);
      @(negedge clock);
      #1;
      regWrite1 = 1'b0;
      regWrite2 = 1'b0;
      reset_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t        e;
      logic [31:0] act;
      forever begin
         @(negedge clock);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.port)
               0:       act = valA;
               1:       act = valB;
               2:       act = dbgValue;
               default: act = {16'h0, writeCount};
            endcase
            checkOutput(e.name, act, e.value);
         end
      end
   end

   initial begin : stimulus
      logic        w1, w2;
      logic [3:0]  r1, r2, sa, sb, dr;
      logic [31:0] v1, v2;
      int          drain;

      errors = 0;
      checks = 0;
      reset_n = 1'b1;
      regWrite1 = 1'b0; regReg1 = RNONE; regValue1 = '0;
      regWrite2 = 1'b0; regReg2 = RNONE; regValue2 = '0;
      srcA = RNONE; srcB = RNONE; dbgReg = RNONE;
      #1;
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      applyReset("reset");

      applyStimulus("single", 1, REG_EDX, 32'hDEAD_BEEF, 0, RNONE, 0, REG_EDX, REG_ESI, REG_EDX, 1);
      applyStimulus("single_rd", 0, RNONE, 0, 0, RNONE, 0, REG_EDX, REG_ESI, REG_EDX, 1);
      applyStimulus("dual", 1, REG_ESI, 32'h0000_0EFC, 1, REG_EAX, 32'h1234, REG_ESI, REG_EAX, REG_EDX, 1);
      applyStimulus("dual_rd", 0, RNONE, 0, 0, RNONE, 0, REG_ESI, REG_EAX, REG_ESI, 1);
      applyStimulus("conflict", 1, REG_ESI, 32'h0000_0F04, 1, REG_ESI, 32'h55, REG_ESI, REG_EDX, REG_EAX, 1);
      applyStimulus("conflict_rd", 0, RNONE, 0, 0, RNONE, 0, REG_ESI, REG_EDX, REG_ESI, 1);
      applyStimulus("rnone", 1, RNONE, 32'hFFFF_FFFF, 1, 4'h9, 32'hFFFF_FFFF, REG_EAX, RNONE, 4'h9, 1);
      applyStimulus("rnone_rd", 0, RNONE, 0, 0, RNONE, 0, REG_ESI, 4'h9, RNONE, 1);
      applyStimulus("bypass", 1, REG_EBX, 32'h77, 0, RNONE, 0, REG_EBX, REG_EBX, REG_EBX, 1);
      applyStimulus("bypass_rd", 0, RNONE, 0, 0, RNONE, 0, REG_EBX, REG_EAX, REG_EBX, 1);
      applyStimulus("bypass2", 1, REG_EDI, 32'h11, 1, REG_EDI, 32'h22, REG_EDI, REG_EDI, REG_EDI, 1);

      for (int i = 0; i < 400; i++) begin
         w1 = 1'($urandom_range(0, 1));
         w2 = 1'($urandom_range(0, 1));
         r1 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         r2 = ($urandom_range(0, 4) == 0) ? r1 : 4'($urandom_range(0, 15));
         v1 = $urandom;
         v2 = $urandom;
         sa = ($urandom_range(0, 2) == 0) ? r1 : 4'($urandom_range(0, 15));
         sb = ($urandom_range(0, 2) == 0) ? r2 : 4'($urandom_range(0, 15));
         dr = 4'($urandom_range(0, 15));
         applyStimulus("random", w1, r1, v1, w2, r2, v2, sa, sb, dr, 1);
      end

      applyReset("reset_mid");
      applyStimulus("post_reset", 0, RNONE, 0, 0, RNONE, 0, REG_ESI, REG_EDX, REG_EAX, 1);

      // Drive the counter past 16'hFFFF with dual distinct writes.
      for (int i = 0; i < 32770; i++)
         applyStimulus("saturate", 1, REG_EAX, 32'(i), 1, REG_ECX, 32'(~i), REG_EAX, REG_ECX, REG_EAX,
                       (i >= 32766));
      applyStimulus("saturate_hold", 1, REG_EBX, 32'h9, 0, RNONE, 0, REG_EAX, REG_ECX, REG_EBX, 1);
      applyStimulus("final", 0, RNONE, 0, 0, RNONE, 0, REG_EBX, REG_ECX, REG_EAX, 1);

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(negedge clock);
         drain++;
      end
      @(posedge clock);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
